// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller.
package disp_pkg;

    localparam int unsigned DEF_NUM_DIGITS   = 4;
    localparam int unsigned DEF_SCAN_DIV     = 50000;
    localparam int unsigned DEF_BLANK_CYCLES = 16;

    // All-ones nibble decodes to "all segments off" on the board decoder.
    localparam logic [3:0] BCD_BLANK = 4'b1111;

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot counter and digit index for the display scan, with end-of-guard,
// end-of-slot and end-of-frame strobes decoded from the counter state.
module scan_timer
    import disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned SCAN_DIV     = DEF_SCAN_DIV,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               i_en,
    input  logic                               i_clr,
    output logic [idx_width(NUM_DIGITS)-1:0]   o_idx,
    output logic                               o_guard_last,
    output logic                               o_slot_last,
    output logic                               o_frame_last,
    output logic                               o_frame_pre
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = idx_width(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(SCAN_DIV - 2);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_idx_last;

    assign w_idx_last   = (r_idx == IDX_LAST);
    assign o_idx        = r_idx;
    assign o_guard_last = (r_cnt == CNT_GUARD);
    assign o_slot_last  = (r_cnt == CNT_LAST);
    assign o_frame_last = o_slot_last && w_idx_last;
    // One cycle ahead of the frame boundary, so the frame pulse can be registered.
    assign o_frame_pre  = (r_cnt == CNT_PRE) && w_idx_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (i_en) begin
            if (o_slot_last) begin
                r_cnt <= '0;
                r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed BCD digit scanner with guard blanking, leading-zero
// suppression and a frame-synchronous double-buffered display register.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned SCAN_DIV     = DEF_SCAN_DIV,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    disp_en,
    input  logic                    lz_en,
    input  logic                    upd_req,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    output logic                    upd_ack,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int unsigned IDX_W  = idx_width(NUM_DIGITS);
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_guard_last;
    logic                  w_slot_last;
    logic                  w_frame_last;
    logic                  w_frame_pre;
    logic                  w_capture;
    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic [NUM_DIGITS-1:0] w_an_nxt;
    logic [NUM_DIGITS-1:0] w_an_sel;
    logic [NUM_DIGITS-1:0] w_supp;
    logic [3:0]            r_bcd;
    logic [3:0]            w_bcd_nxt;
    logic [3:0]            w_nib;
    logic [DATA_W-1:0]     r_disp;
    logic                  r_ack;
    logic                  r_frame_done;

    scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .i_en         (disp_en),
        .i_clr        (~disp_en),
        .o_idx        (w_idx),
        .o_guard_last (w_guard_last),
        .o_slot_last  (w_slot_last),
        .o_frame_last (w_frame_last),
        .o_frame_pre  (w_frame_pre)
    );

    // A digit is dark when it and every more significant digit hold zero.
    always_comb begin
        logic v_run;
        v_run  = lz_en;
        w_supp = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_run     = v_run && (r_disp[4*i +: 4] == 4'd0);
            w_supp[i] = v_run;
        end
    end

    assign w_nib     = r_disp[{w_idx, 2'b00} +: 4];
    assign w_an_sel  = ~(NUM_DIGITS'(1) << w_idx);
    assign w_capture = disp_en && w_frame_last && upd_req;

    always_comb begin
        w_state_nxt = r_state;
        w_an_nxt    = '1;
        w_bcd_nxt   = BCD_BLANK;
        if (!disp_en) begin
            w_state_nxt = ST_GUARD;
        end else begin
            case (r_state)
                ST_GUARD: if (w_guard_last) w_state_nxt = ST_DRIVE;
                ST_DRIVE: if (w_slot_last)  w_state_nxt = ST_GUARD;
                default:  w_state_nxt = ST_GUARD;
            endcase
        end
        if (disp_en && (w_state_nxt == ST_DRIVE) && !w_supp[w_idx]) begin
            w_an_nxt  = w_an_sel;
            w_bcd_nxt = w_nib;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_GUARD;
            r_an_n       <= '1;
            r_bcd        <= BCD_BLANK;
            r_ack        <= 1'b0;
            r_frame_done <= 1'b0;
            r_disp       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_an_n       <= w_an_nxt;
            r_bcd        <= w_bcd_nxt;
            r_ack        <= w_capture;
            r_frame_done <= disp_en && w_frame_pre;
            if (w_capture) begin
                r_disp <= upd_data;
            end
        end
    end

    assign upd_ack    = r_ack;
    assign bcd_out    = r_bcd;
    assign an_n       = r_an_n;
    assign frame_done = r_frame_done;

endmodule
